// File: rtl/clkdiv_pkg.sv
// Shared state encoding and divisor helpers for the programmable clock divider
// family (single and future multi-channel variants).
package clkdiv_pkg;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

  // duty=0: high phase is ceil(div/2); duty=1: requested high clamped to 1..div-1.
  function automatic int unsigned high_len(input int unsigned div,
                                           input int unsigned high = 0,
                                           input bit          duty = 1'b0);
    if (!duty) return (div + 1) / 2;
    if (high < 1) return 1;
    if (high > div - 1) return div - 1;
    return high;
  endfunction

endpackage

// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider with glitch-free divisor change at period
// boundaries. Define CLKDIV_DUTY_EN to add a programmable high-phase length (cfg_high).
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [WIDTH-1:0] cfg_high,
`endif
  output logic             cfg_ready,
  output logic             divclk,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'((DEFAULT_DIV + 1) / 2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] high_reg, high_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic [WIDTH-1:0] pend_high_reg, pend_high_next;
  logic             divclk_reg, tick_reg;
  logic             accept, wrap;
  logic [WIDTH-1:0] cfg_div_c, cfg_high_in, high_eff;

`ifdef CLKDIV_DUTY_EN
  localparam bit DUTY = 1'b1;
  assign cfg_high_in = cfg_high;
`else
  localparam bit DUTY = 1'b0;
  assign cfg_high_in = '0;
`endif

  assign cfg_ready = (state_reg != RUN_PEND);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_div_c = WIDTH'(clamp_div(32'(cfg_div)));
  assign wrap      = (cnt_reg == div_reg - ONE);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    div_next       = div_reg;
    high_next      = high_reg;
    pend_next      = pend_reg;
    pend_high_next = pend_high_reg;
    if (!en) begin
      // Stopping always leaves the newest divisor in effect for the next start.
      state_next = STOP;
      cnt_next   = '0;
      if (state_reg == RUN_PEND) begin
        div_next  = pend_reg;
        high_next = pend_high_reg;
      end else if (accept) begin
        div_next  = cfg_div_c;
        high_next = cfg_high_in;
      end
    end else begin
      unique case (state_reg)
        STOP: begin
          if (accept) begin
            div_next  = cfg_div_c;
            high_next = cfg_high_in;
          end
          state_next = RUN;
          cnt_next   = '0;
        end
        RUN: begin
          cnt_next = wrap ? '0 : cnt_reg + ONE;
          if (accept) begin
            pend_next      = cfg_div_c;
            pend_high_next = cfg_high_in;
            state_next     = RUN_PEND;
          end
        end
        RUN_PEND: begin
          if (wrap) begin
            cnt_next   = '0;
            div_next   = pend_reg;
            high_next  = pend_high_reg;
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
        default: begin
          state_next = STOP;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs follow the next count with the next divisor, so a new period is clean.
  assign high_eff = WIDTH'(high_len(32'(div_next), 32'(high_next), DUTY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= STOP;
      cnt_reg       <= '0;
      div_reg       <= DEF_DIV;
      high_reg      <= DEF_HIGH;
      pend_reg      <= DEF_DIV;
      pend_high_reg <= DEF_HIGH;
      divclk_reg    <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      div_reg       <= div_next;
      high_reg      <= high_next;
      pend_reg      <= pend_next;
      pend_high_reg <= pend_high_next;
      divclk_reg    <= en && (cnt_next < high_eff);
      tick_reg      <= en && (cnt_next == '0);
    end
  end

  assign divclk  = divclk_reg;
  assign tick    = tick_reg;
  assign cur_div = div_reg;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Scoreboard bench for clkdiv_prog: a period-position reference model pushes the
// expected outputs per clock, a monitor pops and compares after each rising edge.
module tb_clkdiv_prog;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 100;

  logic             clk = 1'b0;
  logic             rst, en, cfg_valid;
  logic [WIDTH-1:0] cfg_div, cfg_high;
  logic             cfg_ready, divclk, tick;
  logic [WIDTH-1:0] cur_div;

  always #5 clk = ~clk;

  clkdiv_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_high (cfg_high),
`endif
    .cfg_ready(cfg_ready),
    .divclk   (divclk),
    .tick     (tick),
    .cur_div  (cur_div)
  );

  typedef struct packed {
    logic             divclk;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             ready;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: running flag, position within the current period, divisor,
  // requested high length and an optional single pending (divisor, high) pair.
  bit m_run, m_has_pend;
  int m_pos, m_div, m_high, m_pend_div, m_pend_high;

  function automatic int clampd(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int raw_high(input int d, input int h);
`ifdef CLKDIV_DUTY_EN
    return h + 0 * d;
`else
    return (d + 1) / 2 + 0 * h;
`endif
  endfunction

  function automatic int model_hi();
    if (m_high < 1) return 1;
    if (m_high > m_div - 1) return m_div - 1;
    return m_high;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.divclk  = m_run && (m_pos < model_hi());
    e.tick    = m_run && (m_pos == 0);
    e.cur_div = WIDTH'(m_div);
    e.ready   = !m_has_pend;
    return e;
  endfunction

  task automatic step_model(input bit r, input bit e, input bit v, input int d, input int h);
    bit acc;
    int cd, ch;
    acc = v && !m_has_pend;
    cd  = clampd(d);
    ch  = raw_high(cd, h);
    if (r) begin
      m_run = 0; m_pos = 0; m_div = DEFAULT_DIV; m_high = (DEFAULT_DIV + 1) / 2; m_has_pend = 0;
    end else if (!e) begin
      if (m_has_pend) begin m_div = m_pend_div; m_high = m_pend_high; end
      else if (acc) begin m_div = cd; m_high = ch; end
      m_run = 0; m_pos = 0; m_has_pend = 0;
    end else if (!m_run) begin
      if (acc) begin m_div = cd; m_high = ch; end
      m_run = 1; m_pos = 0;
    end else begin
      if (m_pos == m_div - 1) begin
        m_pos = 0;
        if (m_has_pend) begin m_div = m_pend_div; m_high = m_pend_high; m_has_pend = 0; end
      end else begin
        m_pos++;
      end
      if (acc) begin m_pend_div = cd; m_pend_high = ch; m_has_pend = 1; end
    end
  endtask

  // One clock of stimulus: drive inputs, advance model, queue expectation.
  task automatic cycle(input bit e, input bit v, input int d, input int h);
    en = e; cfg_valid = v; cfg_div = WIDTH'(d); cfg_high = WIDTH'(h);
    if (v && !m_has_pend && !rst)
      $display("cfg transfer: div=%0d high=%0d en=%0b", d, h, e);
    step_model(rst, e, v, d, h);
    exp_q.push_back(model_exp());
    @(negedge clk);
  endtask

  task automatic offer(input int d, input int h);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      done = !m_has_pend;
      cycle(1'b1, 1'b1, d, h);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL offer_timeout div=%0d: transfer not accepted within 300 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0);
  endtask

  task automatic check_reset(input string name);
    vectors++;
    if (divclk !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1 || cur_div !== WIDTH'(DEFAULT_DIV)) begin
      miscompares++;
      $display("FAIL %s: divclk=%b tick=%b cfg_ready=%b cur_div=%0d, expected 0 0 1 %0d",
               name, divclk, tick, cfg_ready, cur_div, DEFAULT_DIV);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (divclk !== e.divclk || tick !== e.tick || cur_div !== e.cur_div || cfg_ready !== e.ready) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t: got divclk=%b tick=%b cur_div=%0d ready=%b, expected %b %b %0d %b",
                   $time, divclk, tick, cur_div, cfg_ready, e.divclk, e.tick, e.cur_div, e.ready);
        end
      end
    end
  end

  initial begin : stimulus
    bit found;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
    step_model(1'b1, 1'b0, 1'b0, 0, 0);
    #2;
    check_reset("reset_state");
    @(negedge clk);
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 0, 0);

    // Default divisor: first tick one cycle after en, then 100-cycle periods.
    idle(210);
    // Change to 7 mid-period.
    idle(30);
    offer(7, 0);
    idle(100);
    // Clamped divisors.
    offer(0, 0);
    idle(10);
    offer(1, 0);
    idle(10);
    // Drop en while a divisor of 5 is pending, then restart.
    offer(5, 0);
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    idle(20);
    // Accept exactly in the boundary cycle: 4 -> 6.
    offer(4, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!m_has_pend && m_div == 4 && m_run && m_pos == m_div - 1) found = 1;
      else cycle(1'b1, 1'b0, 0, 0);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL boundary_wait: boundary of divisor 4 not reached, got div=%0d", m_div);
    end
    cycle(1'b1, 1'b1, 6, 0);
    idle(30);
`ifdef CLKDIV_DUTY_EN
    offer(10, 0);
    idle(25);
    offer(10, 15);
    idle(25);
`endif

    // Randomized traffic with short and long divisors.
    for (int i = 0; i < 1500; i++) begin
      bit e, v;
      int d;
      e = ($urandom_range(0, 49) != 0);
      v = ($urandom_range(0, 19) == 0) && !m_has_pend;
      d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      cycle(e, v, d, $urandom_range(0, 255));
    end

    // Reset in the middle of a high phase.
    offer(20, 10);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (!m_has_pend && m_run && m_pos > 0 && m_pos < model_hi() - 1) found = 1;
      else cycle(1'b1, 1'b0, 0, 0);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL high_phase_wait: no mid high phase reached, got pos=%0d", m_pos);
    end
    rst = 1'b1;
    #1;
    check_reset("reset_mid_high");
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    idle(20);

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
Runtime-programmable clock divider. It is the successor to the fixed-factor divider, with a parametrised counter width and a divisor loaded at run time through a valid/ready handshake. The divisor change takes effect glitch-free at a period boundary. It produces a registered divided clock and a one-cycle tick strobe for downstream logic (UART baud, SPI SCLK, debounce timers) in the single clk domain.

Parameters:
WIDTH, 8, width of divisor and period counter
DEFAULT_DIV, 100, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2**WIDTH-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low stops and clears the divider
cfg_valid  input  1  new divisor offered
cfg_div  input  WIDTH  offered divisor, in input cycles per output period
cfg_ready  output  1  divider can accept a divisor
divclk  output  1  divided clock, registered
tick  output  1  one-cycle pulse on each divclk rising edge
cur_div  output  WIDTH  divisor currently in effect

Behaviour:
- Reset (async, rst=1):
  - state=STOP, cnt=0, div_q=DEFAULT_DIV, pending empty.
  - Outputs: divclk=0, tick=0, cfg_ready=1, cur_div=DEFAULT_DIV.
- Divisor clamp: cfg_div values 0 and 1 are stored as 2. There is no combinational bypass of clk.
- Period D=div_q: high phase H=ceil(D/2), low phase D-H. Period starts with the high phase.
- cnt runs 0..D-1, then wraps to 0.
  - divclk=1 while cnt<H.
  - tick=1 only in the cnt=0 cycle.
  - Both are registered: cnt and the outputs update on the same edge.
- State machine: STOP, RUN, RUN_PEND.
  - STOP: cnt=0, divclk=0, tick=0.
    - An accepted cfg loads div_q directly; state stays STOP.
    - en=1 sampled -> RUN. The next edge gives cnt=0, divclk=1, tick=1 (1-cycle latency from en).
  - RUN: counting.
    - An accepted cfg is stored in the pending register -> RUN_PEND.
  - RUN_PEND: counting with the old div_q; cfg_ready=0.
    - At the boundary cycle (cnt==D-1), div_q<=pending and cnt<=0 -> RUN.
    - The new period begins with the new divisor.
  - Any state, en=0 sampled -> STOP on the next edge.
    - A pending divisor is committed to div_q at that edge.
    - cnt and outputs are cleared; cfg_ready returns to 1.
- Handshake:
  - cfg_ready=1 in STOP and RUN, 0 in RUN_PEND.
  - Transfer occurs when cfg_valid&&cfg_ready at an edge.
  - cfg_div must be stable while cfg_valid=1 and cfg_ready=0.
- Simultaneous events:
  - Accept in the RUN boundary cycle: the value is stored as pending and applied at the next boundary, not the current one.
  - en=0 together with an accept: the value is committed to div_q; state goes to STOP.
- cur_div always equals div_q, including during RUN_PEND (old value).
- Reset mid-period: all state returns to reset values immediately; no partial tick is emitted.
- Divisor change never produces a high or low phase shorter than min(old,new) phase length.

Optional Feature:
CLKDIV_DUTY_EN.
- Defined:
  - Adds input cfg_high (WIDTH), transferred with cfg_div and held pending alongside it.
  - H=cfg_high clamped to 1..D-1.
  - Reset H=ceil(DEFAULT_DIV/2).
- Undefined:
  - cfg_high is absent; H=ceil(D/2) always.
  - Behaviour is otherwise identical.

Decomposition:
- Package clkdiv_pkg holds:
  - state enum (STOP, RUN, RUN_PEND)
  - constant DIV_MIN=2
  - functions clamp_div() and high_len(div[,high]), shared with future multi-channel variants.
- No sub-module: the pending register, counter and FSM stay in clkdiv_prog.

Test Plan:
- Reset, en=1, no cfg, DEFAULT_DIV=100 -> first tick 1 cycle after en; divclk high 50 / low 50; tick period 100; cur_div=100.
- cfg_div=7 accepted mid-period in RUN -> cfg_ready=0 until the boundary; next periods are 7 cycles, high 4, low 3; cur_div changes 100->7 at the boundary edge.
- cfg_div=0 and cfg_div=1 -> cur_div=2; divclk toggles every cycle; tick every 2 cycles.
- en dropped in RUN_PEND with pending 5 -> next edge divclk=0, cnt=0, cur_div=5, cfg_ready=1; en re-raised -> 5-cycle periods.
- Accept coincident with boundary (div 4->6) -> one more 4-cycle period, then 6-cycle periods.
- rst pulsed mid high phase -> all outputs immediately 0/defaults; cur_div=DEFAULT_DIV; with CLKDIV_DUTY_EN, cfg_div=10, cfg_high=0 -> H=1; cfg_high=15 -> H=9.
